// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 round-key generator: one key per valid/ready handshake, forward or inverse.
// The S-box is computed as GF(2^8) inverse plus affine map, so no table ROM is needed.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      else      p = p;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_sched_iter #(
  parameter int          NR        = 10,
  parameter logic [7:0]  RCON_LAST = 8'h36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         inv_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         last_o,
  output logic [127:0] lastkey_o,
  output logic         lastkey_valid_o
);

  localparam logic [3:0] IDX_LAST = 4'(NR);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_next;
  logic [7:0]   rcon, rcon_next;
  logic         dir_inv;
  logic         is_last, hs;
  logic [31:0]  w0, w1, w2, w3, p1, p2, p3;
  logic [31:0]  sub_in, rot, sub_out, t;
  logic [127:0] key_next;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_i ? RUN : IDLE;
      RUN:     state_next = (hs && is_last) ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    busy_o     = 1'b0;
    rk_valid_o = 1'b0;
    case (state)
      RUN: begin
        busy_o     = 1'b1;
        rk_valid_o = 1'b1;
      end
      default: begin
        busy_o     = 1'b0;
        rk_valid_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    is_last = dir_inv ? (rk_idx_o == 4'd0) : (rk_idx_o == IDX_LAST);
    last_o  = (state == RUN) && is_last;
    hs      = rk_valid_o & rk_ready_i;
  end

  // one shared S-box row: forward feeds w3, inverse feeds the recovered w3 of the previous key
  always_comb begin
    w0     = rk_o[31:0];
    w1     = rk_o[63:32];
    w2     = rk_o[95:64];
    w3     = rk_o[127:96];
    p3     = w3 ^ w2;
    p2     = w2 ^ w1;
    p1     = w1 ^ w0;
    sub_in = dir_inv ? p3 : w3;
    rot    = {sub_in[7:0], sub_in[31:8]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*g +: 8]), .s(sub_out[8*g +: 8]));
  end

  always_comb begin
    t = sub_out ^ {24'h000000, rcon};
    if (dir_inv) begin
      key_next  = {p3, p2, p1, w0 ^ t};
      rcon_next = (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};
    end else begin
      key_next[31:0]   = w0 ^ t;
      key_next[63:32]  = w1 ^ key_next[31:0];
      key_next[95:64]  = w2 ^ key_next[63:32];
      key_next[127:96] = w3 ^ key_next[95:64];
      rcon_next        = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_o            <= 128'h0;
      rk_idx_o        <= 4'd0;
      rcon            <= 8'h00;
      dir_inv         <= 1'b0;
      lastkey_o       <= 128'h0;
      lastkey_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rk_o     <= key_i;
            dir_inv  <= inv_i;
            rk_idx_o <= inv_i ? IDX_LAST : 4'd0;
            rcon     <= inv_i ? RCON_LAST : 8'h01;
            if (!inv_i) lastkey_valid_o <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            if (is_last) begin
              if (!dir_inv) begin
                lastkey_o       <= rk_o;
                lastkey_valid_o <= 1'b1;
              end
            end else begin
              rk_o     <= key_next;
              rk_idx_o <= dir_inv ? rk_idx_o - 4'd1 : rk_idx_o + 4'd1;
              rcon     <= rcon_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Self-checking bench: randomized passes compared with a byte-level FIPS-197 key expansion model.
`timescale 1ns/1ps
module tb_aes_key_sched_iter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, inv_in = 1'b0, ready = 1'b0;
  logic [127:0] key_in = 128'h0;

  logic a_busy, a_valid, a_last, a_lkv, b_busy, b_valid, b_last, b_lkv;
  logic [127:0] a_rk, a_lk, b_rk, b_lk;
  logic [3:0] a_idx, b_idx;

  logic o_busy, o_valid, o_last, o_lkv;
  logic [127:0] o_rk, o_lk;
  logic [3:0] o_idx;
  bit sel = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_k [0:15];
  logic [127:0] got_rk[$];
  int           got_idx[$];
  bit           got_last[$];
  int viol, cycles;
  bit timeout;
  logic end_busy, end_valid;

  always #5 clk = ~clk;

  aes_key_sched_iter dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .inv_i(inv_in), .key_i(key_in),
    .busy_o(a_busy), .rk_valid_o(a_valid), .rk_ready_i(ready), .rk_o(a_rk),
    .rk_idx_o(a_idx), .last_o(a_last), .lastkey_o(a_lk), .lastkey_valid_o(a_lkv));

  aes_key_sched_iter #(.NR(2), .RCON_LAST(8'h02)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .inv_i(inv_in), .key_i(key_in),
    .busy_o(b_busy), .rk_valid_o(b_valid), .rk_ready_i(ready), .rk_o(b_rk),
    .rk_idx_o(b_idx), .last_o(b_last), .lastkey_o(b_lk), .lastkey_valid_o(b_lkv));

  always_comb begin
    o_busy  = sel ? b_busy  : a_busy;
    o_valid = sel ? b_valid : a_valid;
    o_last  = sel ? b_last  : a_last;
    o_lkv   = sel ? b_lkv   : a_lkv;
    o_rk    = sel ? b_rk    : a_rk;
    o_lk    = sel ? b_lk    : a_lk;
    o_idx   = sel ? b_idx   : a_idx;
  end

  // S-box table from the generator-3 walk (independent of the GF-inverse form)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = h[127-8*j -: 8];
    return r;
  endfunction

  task automatic expand(input logic [127:0] key, input int nr);
    logic [7:0] wb [0:63][0:3];
    logic [7:0] tmp [0:3];
    logic [7:0] rc, t0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wb[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = wb[i-1][j];
      if (i % 4 == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[t0];
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      for (int j = 0; j < 4; j++) wb[i][j] = wb[i-4][j] ^ tmp[j];
    end
    for (int r = 0; r <= nr; r++)
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < 4; j++) exp_k[r][8*(4*w+j) +: 8] = wb[4*r+w][j];
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_pass(input bit s, input bit inv, input logic [127:0] key);
    @(negedge clk);
    sel = s; key_in = key; inv_in = inv;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // records the accepted stream, hold-stability violations and cycle count
  task automatic collect(input int pct, input bit pulse);
    bit done, have_prev, r;
    logic [127:0] prk; logic [3:0] pidx; logic plast;
    got_rk.delete(); got_idx.delete(); got_last.delete();
    viol = 0; cycles = 0; timeout = 0; done = 0; have_prev = 0;
    prk = '0; pidx = '0; plast = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (pulse) begin
        key_in = rnd128(); inv_in = $urandom_range(1);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (o_valid) begin
        if (have_prev && (o_rk !== prk || o_idx !== pidx || o_last !== plast)) viol++;
        r = ($urandom_range(99) < pct);
        ready = r;
        if (r) begin
          got_rk.push_back(o_rk); got_idx.push_back(int'(o_idx)); got_last.push_back(o_last);
          have_prev = 0;
          if (o_last) done = 1;
        end else begin
          have_prev = 1; prk = o_rk; pidx = o_idx; plast = o_last;
        end
      end else begin
        ready = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    ready = 1'b0; start_a = 1'b0; start_b = 1'b0;
    timeout = !done;
    end_busy = o_busy; end_valid = o_valid;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_busy, a_valid, a_last, a_lkv, a_idx, a_rk, a_lk} !== '0) begin
      errors++; $display("FAIL reset_a: got busy=%b valid=%b idx=%0d rk=%h want all 0", a_busy, a_valid, a_idx, a_rk);
    end
    checks++;
    if ({b_busy, b_valid, b_last, b_lkv, b_idx, b_rk, b_lk} !== '0) begin
      errors++; $display("FAIL reset_b: got busy=%b valid=%b idx=%0d want all 0", b_busy, b_valid, b_idx);
    end
  endtask

  task automatic test_fwd();
    logic [127:0] key;
    key = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand(key, 10);
    start_pass(0, 0, key);
    collect(100, 0);
    checks++;
    if (timeout || got_rk.size() != 11 || cycles != 11) begin
      errors++; $display("FAIL fwd_count: got %0d keys in %0d cycles want 11 in 11", got_rk.size(), cycles);
    end
    for (int i = 0; i < got_rk.size() && i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_k[i] || got_idx[i] != i || got_last[i] != (i == 10)) begin
        errors++; $display("FAIL fwd_key%0d: got %h idx %0d last %b want %h", i, got_rk[i], got_idx[i], got_last[i], exp_k[i]);
      end
    end
    checks++;
    if (got_rk.size() > 1 && got_rk[1] !== fips(128'ha0fafe1788542cb123a339392a6c7605)) begin
      errors++; $display("FAIL fwd_fips1: got %h", got_rk[1]);
    end
    checks++;
    if (a_lk !== fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6) || a_lkv !== 1'b1) begin
      errors++; $display("FAIL fwd_lastkey: got %h v=%b want %h v=1", a_lk, a_lkv, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    end
    checks++;
    if (end_busy !== 1'b0 || end_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_idle: got busy=%b valid=%b want 0 0", end_busy, end_valid);
    end
  endtask

  task automatic test_inv();
    expand(fips(128'h2b7e151628aed2a6abf7158809cf4f3c), 10);
    start_pass(0, 1, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    collect(100, 0);
    checks++;
    if (timeout || got_rk.size() != 11) begin
      errors++; $display("FAIL inv_count: got %0d want 11", got_rk.size());
    end
    for (int i = 0; i < got_rk.size() && i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_k[10-i] || got_idx[i] != 10 - i || got_last[i] != (i == 10)) begin
        errors++; $display("FAIL inv_key%0d: got %h idx %0d want %h idx %0d", i, got_rk[i], got_idx[i], exp_k[10-i], 10-i);
      end
    end
    checks++;
    if (got_rk.size() > 1 && got_rk[1] !== fips(128'hac7766f319fadc2128d12941575c006e)) begin
      errors++; $display("FAIL inv_fips9: got %h", got_rk[1]);
    end
    checks++;
    if (a_lkv !== 1'b1) begin
      errors++; $display("FAIL inv_lkv_kept: got %b want 1", a_lkv);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    for (int n = 0; n < 4; n++) begin
      bit inv;
      key = rnd128();
      inv = (n == 3);
      expand(key, 10);
      start_pass(0, inv, inv ? exp_k[10] : key);
      collect(50, 0);
      checks++;
      if (timeout || got_rk.size() != 11 || viol != 0) begin
        errors++; $display("FAIL bp%0d_stream: got %0d keys viol %0d want 11 keys viol 0", n, got_rk.size(), viol);
      end
      for (int i = 0; i < got_rk.size() && i < 11; i++) begin
        checks++;
        if (got_rk[i] !== exp_k[inv ? 10-i : i]) begin
          errors++; $display("FAIL bp%0d_key%0d: got %h want %h", n, i, got_rk[i], exp_k[inv ? 10-i : i]);
        end
      end
    end
  endtask

  task automatic test_start_pulse();
    logic [127:0] key;
    key = rnd128();
    expand(key, 10);
    start_pass(0, 0, key);
    collect(100, 1);
    checks++;
    if (timeout || got_rk.size() != 11 || end_busy !== 1'b0) begin
      errors++; $display("FAIL pulse_stream: got %0d keys busy_end=%b want 11 and 0", got_rk.size(), end_busy);
    end
    for (int i = 0; i < got_rk.size() && i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_k[i] || got_idx[i] != i) begin
        errors++; $display("FAIL pulse_key%0d: got %h idx %0d want %h", i, got_rk[i], got_idx[i], exp_k[i]);
      end
    end
    start_pass(0, 1, exp_k[10]);
    checks++;
    if (o_valid !== 1'b1 || o_idx !== 4'd10 || o_rk !== exp_k[10]) begin
      errors++; $display("FAIL pulse_restart: got valid=%b idx=%0d want 1 10", o_valid, o_idx);
    end
    collect(100, 0);
    checks++;
    if (timeout || got_rk.size() != 11 || got_rk[10] !== key) begin
      errors++; $display("FAIL pulse_inv: got %0d keys want 11 ending in key", got_rk.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] key;
    bit found;
    key = rnd128();
    expand(key, 10);
    start_pass(0, 0, key);
    found = 0;
    ready = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      if (a_idx == 4'd5) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found || a_rk !== exp_k[5]) begin
      errors++; $display("FAIL rst_reach5: got idx %0d rk %h want 5 %h", a_idx, a_rk, exp_k[5]);
    end
    reset = 1'b1; ready = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_valid, a_last, a_lkv, a_idx, a_rk, a_lk} !== '0) begin
      errors++; $display("FAIL rst_mid: got busy=%b valid=%b idx=%0d lkv=%b want all 0", a_busy, a_valid, a_idx, a_lkv);
    end
    @(negedge clk);
    reset = 1'b0;
    start_pass(0, 1, exp_k[10]);
    collect(100, 0);
    checks++;
    if (timeout || got_rk.size() != 11) begin
      errors++; $display("FAIL rst_inv_count: got %0d want 11", got_rk.size());
    end
    for (int i = 0; i < got_rk.size() && i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_k[10-i]) begin
        errors++; $display("FAIL rst_inv_key%0d: got %h want %h", i, got_rk[i], exp_k[10-i]);
      end
    end
    checks++;
    if (a_lkv !== 1'b0 || a_lk !== 128'h0) begin
      errors++; $display("FAIL rst_lkv: got %b %h want 0", a_lkv, a_lk);
    end
  endtask

  task automatic test_nr2();
    logic [127:0] key;
    logic [127:0] fwd [0:2];
    key = rnd128();
    expand(key, 2);
    start_pass(1, 0, key);
    collect(50, 0);
    checks++;
    if (timeout || got_rk.size() != 3 || viol != 0) begin
      errors++; $display("FAIL nr2_fwd_count: got %0d keys viol %0d want 3 0", got_rk.size(), viol);
    end
    for (int i = 0; i < 3; i++) begin
      fwd[i] = (i < got_rk.size()) ? got_rk[i] : 128'h0;
      checks++;
      if (fwd[i] !== exp_k[i]) begin
        errors++; $display("FAIL nr2_fwd%0d: got %h want %h", i, fwd[i], exp_k[i]);
      end
    end
    checks++;
    if (b_lk !== exp_k[2] || b_lkv !== 1'b1) begin
      errors++; $display("FAIL nr2_lastkey: got %h v=%b want %h v=1", b_lk, b_lkv, exp_k[2]);
    end
    start_pass(1, 1, fwd[2]);
    collect(50, 0);
    checks++;
    if (timeout || got_rk.size() != 3) begin
      errors++; $display("FAIL nr2_inv_count: got %0d want 3", got_rk.size());
    end
    for (int i = 0; i < got_rk.size() && i < 3; i++) begin
      checks++;
      if (got_rk[i] !== fwd[2-i] || got_idx[i] != 2 - i || got_last[i] != (i == 2)) begin
        errors++; $display("FAIL nr2_inv%0d: got %h idx %0d want %h idx %0d", i, got_rk[i], got_idx[i], fwd[2-i], 2-i);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    build_sbox();
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_fwd();
    test_inv();
    test_backpressure();
    test_start_pulse();
    test_reset_mid();
    test_nr2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
